// File: rtl/vga_rx_check_if.sv
// vga_rx_check_if: VGA sink bundle of active-low syncs and packed RRGGBB pixel
interface vga_rx_check_if;
  logic       hsync_n;
  logic       vsync_n;
  logic [5:0] rgb;
  modport master (output hsync_n, vsync_n, rgb);
  modport slave  (input hsync_n, vsync_n, rgb);
endinterface

// File: rtl/vga_rx_check.sv
// vga_rx_check: recovers VGA position from sync edges, checks timing, tracks lock, checksums frames
module vga_rx_check #(
  parameter int H_VIEW       = 640,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC_W     = 96,
  parameter int H_TOTAL      = 800,
  parameter int V_VIEW       = 480,
  parameter int V_SYNC_START = 490,
  parameter int V_TOTAL      = 525
) (
  input  logic             clk,
  input  logic             reset_n,
  vga_rx_check_if.slave    vga,
  output logic [9:0]       rx_hpos,
  output logic [9:0]       rx_vpos,
  output logic [5:0]       rx_rgb,
  output logic             rx_visible,
  output logic             locked,
  output logic             frame_done,
  output logic [15:0]      frame_sum,
  output logic             err,
  output logic [7:0]       err_count
);
  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;
  state_t      state;
  logic        s1_hs, s1_vs, s2_hs, s2_vs;
  logic [5:0]  s1_rgb;
  logic [1:0]  primed;
  logic        hs_seen, vs_seen, hw_arm, ferr;
  logic [11:0] line_cnt, hw_cnt;
  logic [10:0] fl_cnt;
  logic [15:0] acc;
  logic        hs_edge, hs_release, vs_edge, h_step, line_err, hw_err, fl_ok, fl_err, e_now, vis_n;
  logic [9:0]  hpos_n, vpos_n;
  // primed keeps edges quiet until S1 and S2 both hold real samples after reset
  always_comb begin
    hs_edge    = primed[1] && !s1_hs && s2_hs;
    hs_release = primed[1] && s1_hs && !s2_hs;
    vs_edge    = primed[1] && !s1_vs && s2_vs;
    h_step     = !hs_edge && rx_hpos == 10'(H_TOTAL - 1);
    hpos_n     = hs_edge ? 10'(H_SYNC_START) : h_step ? 10'd0 : rx_hpos + 10'd1;
    vpos_n     = vs_edge ? 10'(V_SYNC_START) : !h_step ? rx_vpos :
                 rx_vpos == 10'(V_TOTAL - 1) ? 10'd0 : rx_vpos + 10'd1;
    vis_n      = hpos_n < 10'(H_VIEW) && vpos_n < 10'(V_VIEW);
    line_err   = hs_edge && hs_seen && line_cnt != 12'(H_TOTAL);
    hw_err     = hs_release && hw_arm && hw_cnt != 12'(H_SYNC_W);
    fl_ok      = fl_cnt == 11'(V_TOTAL);
    fl_err     = vs_edge && vs_seen && !fl_ok;
    e_now      = line_err || hw_err || fl_err;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      {s1_hs, s1_vs, s2_hs, s2_vs} <= '1;
      s1_rgb     <= '0;
      primed     <= '0;
      rx_hpos    <= '0;
      rx_vpos    <= '0;
      rx_rgb     <= '0;
      rx_visible <= 1'b0;
      hs_seen    <= 1'b0;
      vs_seen    <= 1'b0;
      hw_arm     <= 1'b0;
      line_cnt   <= '0;
      hw_cnt     <= '0;
      fl_cnt     <= '0;
      acc        <= '0;
      err        <= 1'b0;
      err_count  <= '0;
    end else begin
      s1_hs      <= vga.hsync_n;
      s1_vs      <= vga.vsync_n;
      s1_rgb     <= vga.rgb;
      s2_hs      <= s1_hs;
      s2_vs      <= s1_vs;
      primed     <= {primed[0], 1'b1};
      rx_hpos    <= hpos_n;
      rx_vpos    <= vpos_n;
      rx_rgb     <= s1_rgb;
      rx_visible <= vis_n;
      hs_seen    <= hs_seen || hs_edge;
      vs_seen    <= vs_seen || vs_edge;
      hw_arm     <= hs_edge || (hw_arm && !hs_release);
      line_cnt   <= hs_edge ? 12'd1 : line_cnt + 12'(line_cnt != '1);
      hw_cnt     <= hs_edge ? 12'd1 : hw_cnt + 12'(hw_cnt != '1);
      fl_cnt     <= vs_edge ? 11'(hs_edge) : fl_cnt + 11'(hs_edge && fl_cnt != '1);
      acc        <= vs_edge ? '0 : vis_n ? {acc[14:0], acc[15]} ^ {10'b0, s1_rgb} : acc;
      err        <= e_now;
      err_count  <= err_count + 8'(e_now && err_count != '1);
    end
  // a frame-length error at vs_edge belongs to the frame just closed, so the vs branch wins over setting ferr
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state      <= SEARCH;
      locked     <= 1'b0;
      ferr       <= 1'b0;
      frame_done <= 1'b0;
      frame_sum  <= '0;
    end else begin
      frame_done <= vs_edge && state != SEARCH;
      if (vs_edge && state != SEARCH) frame_sum <= acc;
      if (state == SEARCH) begin
        if (vs_edge) begin
          state <= TRACK;
          ferr  <= 1'b0;
        end
      end else if (state == TRACK) begin
        if (vs_edge && !ferr && fl_ok) begin
          state  <= LOCKED;
          locked <= 1'b1;
        end else if (vs_edge) ferr <= 1'b0;
        else if (e_now) ferr <= 1'b1;
      end else if (err || state != LOCKED) begin
        state  <= SEARCH;
        locked <= 1'b0;
      end
    end
endmodule

// File: tb/tb_vga_rx_check.sv
// tb_vga_rx_check: scoreboard bench driving a scaled-down VGA stream into vga_rx_check
module tb_vga_rx_check;
  localparam int HV = 8, HSS = 10, HSW = 4, HT = 20, VV = 6, VSS = 8, VT = 12;
  typedef struct {int cnt; logic lk; int hp;} err_t;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  rx_hpos, rx_vpos;
  logic [5:0]  rx_rgb;
  logic        rx_visible, locked, frame_done, err;
  logic [15:0] frame_sum;
  logic [7:0]  err_count;
  int          checks = 0, failures = 0, cyc = 0, exp_cnt = 0, pos_bad = 0;
  int          lock_cyc = -1, vs_cyc = -1;
  logic        mon_on = 1'b0, chk_fall = 1'b0, pos_on = 1'b0;
  int          ph[2], pv[2];
  logic [5:0]  pr[2];
  logic        pk[2] = '{1'b0, 1'b0};
  logic [15:0] exp_sum[$];
  err_t        exp_err[$];
  vga_rx_check_if vga();
  vga_rx_check #(.H_VIEW(HV), .H_SYNC_START(HSS), .H_SYNC_W(HSW), .H_TOTAL(HT),
                 .V_VIEW(VV), .V_SYNC_START(VSS), .V_TOTAL(VT)) dut (
    .clk(clk), .reset_n(reset_n), .vga(vga), .rx_hpos(rx_hpos), .rx_vpos(rx_vpos),
    .rx_rgb(rx_rgb), .rx_visible(rx_visible), .locked(locked), .frame_done(frame_done),
    .frame_sum(frame_sum), .err(err), .err_count(err_count));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask
  task automatic chk_zero();
    check("zero_rx_hpos", rx_hpos, 0);
    check("zero_rx_vpos", rx_vpos, 0);
    check("zero_rx_rgb", rx_rgb, 0);
    check("zero_rx_visible", rx_visible, 0);
    check("zero_locked", locked, 0);
    check("zero_frame_done", frame_done, 0);
    check("zero_frame_sum", frame_sum, 0);
    check("zero_err", err, 0);
    check("zero_err_count", err_count, 0);
  endtask
  task automatic expect_err(input logic lk, input int hp);
    err_t e;
    exp_cnt = exp_cnt < 255 ? exp_cnt + 1 : 255;
    e.cnt = exp_cnt;
    e.lk = lk;
    e.hp = hp;
    exp_err.push_back(e);
  endtask
  task automatic drive(input int h, input int v, input logic hs, input logic vs, input logic [5:0] px);
    @(negedge clk);
    if (pos_on && pk[1] && (rx_hpos != 10'(ph[1]) || rx_vpos != 10'(pv[1]) || rx_rgb != pr[1] ||
        rx_visible != (ph[1] < HV && pv[1] < VV))) pos_bad++;
    ph[1] = ph[0]; pv[1] = pv[0]; pr[1] = pr[0]; pk[1] = pk[0];
    ph[0] = h; pv[0] = v; pr[0] = px; pk[0] = 1'b1;
    if (!vs && vga.vsync_n && vs_cyc < 0) vs_cyc = cyc;
    vga.hsync_n = hs;
    vga.vsync_n = vs;
    vga.rgb = px;
  endtask
  task automatic frame(input int nl, input int short_l, input int narrow_l, input logic dot, input int rst_l);
    for (int v = 0; v < nl; v++)
      for (int h = 0; h < (v == short_l ? HT - 1 : HT); h++) begin
        drive(h, v, !(h >= HSS && h < HSS + ((narrow_l == -2 || v == narrow_l) ? HSW - 1 : HSW)),
              !(v >= VSS && v < VSS + 2), (dot && v == 0 && h == 0) ? 6'h3F : 6'h00);
        if (v == rst_l && h == 5) begin
          reset_n = 1'b0;
          #1;
          chk_zero();
          reset_n = 1'b1;
          exp_cnt = 0;
        end
      end
  endtask
  initial begin
    err_t e;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (chk_fall) begin
          check("locked_after_err", locked, 0);
          chk_fall = 1'b0;
        end
        if (lock_cyc < 0 && locked) lock_cyc = cyc;
        if (frame_done) begin
          if (exp_sum.size() == 0) check("spurious_frame_done", frame_done, 0);
          else check("frame_sum", frame_sum, exp_sum.pop_front());
        end
        if (err) begin
          if (exp_err.size() == 0) check("spurious_err", err, 0);
          else begin
            e = exp_err.pop_front();
            check("err_count", err_count, e.cnt);
            check("locked_at_err", locked, e.lk);
            check("rx_hpos_at_err", rx_hpos, e.hp);
            chk_fall = 1'b1;
          end
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    vga.hsync_n = 1'b1;
    vga.vsync_n = 1'b1;
    vga.rgb = 6'h00;
    repeat (3) @(negedge clk);
    chk_zero();
    reset_n = 1'b1;
    mon_on = 1'b1;
    frame(VT, -1, -1, 1'b0, -1);
    exp_sum.push_back(16'h0000);
    frame(VT, -1, -1, 1'b0, -1);
    check("lock_latency", lock_cyc - vs_cyc, HT * VT + 2);
    check("locked_clean", locked, 1);
    check("err_count_clean", err_count, 0);
    exp_sum.push_back(16'h0000);
    pos_on = 1'b1;
    frame(VT, -1, -1, 1'b0, -1);
    exp_sum.push_back(16'h801F);
    frame(VT, -1, -1, 1'b1, -1);
    pos_on = 1'b0;
    check("rx_position_pixel", pos_bad, 0);
    exp_sum.push_back(16'h0000);
    frame(VT, -1, -1, 1'b0, -1);
    expect_err(1'b1, HSS);
    frame(VT, 2, -1, 1'b0, -1);
    check("locked_short_line", locked, 0);
    check("err_count_short_line", err_count, 1);
    exp_sum.push_back(16'h0000);
    frame(VT, -1, -1, 1'b0, -1);
    check("relock_short_line", locked, 1);
    expect_err(1'b1, HSS + HSW - 1);
    frame(VT, -1, 2, 1'b0, -1);
    check("locked_narrow_hsync", locked, 0);
    exp_sum.push_back(16'h0000);
    frame(VT, -1, -1, 1'b0, -1);
    check("relock_narrow_hsync", locked, 1);
    frame(VT - 1, -1, -1, 1'b0, 3);
    check("locked_after_reset", locked, 0);
    expect_err(1'b0, 0);
    exp_sum.push_back(16'h0000);
    frame(VT, -1, -1, 1'b0, -1);
    check("track_after_short_frame", locked, 0);
    exp_sum.push_back(16'h0000);
    frame(VT, -1, -1, 1'b0, -1);
    check("lock_after_clean_frame", locked, 1);
    for (int f = 0; f < 25; f++) begin
      for (int l = 0; l < VT; l++) expect_err(f == 0 && l == 0, HSS + HSW - 1);
      if (f > 0) exp_sum.push_back(16'h0000);
      frame(VT, -1, -2, 1'b0, -1);
    end
    check("err_count_saturated", err_count, 255);
    repeat (5) @(negedge clk);
    check("pending_frame_done", exp_sum.size(), 0);
    check("pending_err", exp_err.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
